// File: rtl/misc_v_pkg.sv
// Shared types and constants for the MISC-V hazard scoreboard.
// Holds the scoreboard entry layout, the operand-select encoding and the
// performance counter width used by hazard_scoreboard and hazard_fwd_pick.
package misc_v_pkg;

    // Default register address width (8 architectural registers, r0 = zero).
    localparam int REG_AW_DEF = 3;

    // Destination field width inside a scoreboard entry. Sized for the widest
    // register file the controller supports; narrower addresses zero-extend.
    localparam int SB_RD_W = 8;

    // Operand select encoding: 0 = register file, k = scoreboard entry k-1.
    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] SEL_RF = 3'd0;

    // Performance counter width.
    localparam int CNT_W = 32;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic               valid;
        logic               wr;
        logic               load;
        logic [SB_RD_W-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/hazard_fwd_pick.sv
// Youngest-match priority finder over the scoreboard entries.
// Reports whether any in-flight writer produces the given source register,
// the lowest (youngest) entry index that does, and whether it is a load.
module hazard_fwd_pick
    import misc_v_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = 3
) (
    input  sb_entry_t         entries [DEPTH],
    input  logic [REG_AW-1:0] src,
    input  logic              used,
    output logic              hit,
    output logic [SEL_W-1:0]  idx,
    output logic              isLoad
);

    logic [SB_RD_W-1:0] srcExt;
    logic [DEPTH-1:0]   matchVec;

    assign srcExt = SB_RD_W'(src);

    // Per-entry match: live writer of this register; r0 never matches.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gMatch
            assign matchVec[gi] = used
                                && (srcExt != '0)
                                && entries[gi].valid
                                && entries[gi].wr
                                && (entries[gi].rd == srcExt);
        end
    endgenerate

    // Priority select: scan oldest to youngest so the lowest index wins.
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        isLoad = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (matchVec[i]) begin
                hit    = 1'b1;
                idx    = SEL_W'(i);
                isLoad = entries[i].load;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller for the MISC-V in-order pipeline.
// A shifting scoreboard of in-flight destinations (entry 0 = EX) drives the
// registered EX forward selects, the combinational decode branch-comparator
// selects, load-use / branch-operand stalls and the post-jump flush window.
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt.
module hazard_scoreboard
    import misc_v_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int DEPTH      = 3,
    parameter int LOAD_LAT   = 1,
    parameter int BR_FWD_MIN = 2,
    parameter int FLUSH_LEN  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr,
    input  logic              id_load,
    input  logic              id_branch,
    input  logic              id_jump,
    output logic [SEL_W-1:0]  fwd1_sel,
    output logic [SEL_W-1:0]  fwd2_sel,
    output logic [SEL_W-1:0]  bfwd1_sel,
    output logic [SEL_W-1:0]  bfwd2_sel,
    output logic              stall,
    output logic              flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // Picker slots: two EX operands, then two branch comparator operands.
    localparam int NUM_PICK = 4;
    localparam int P_FWD1   = 0;
    localparam int P_FWD2   = 1;
    localparam int P_BFWD1  = 2;
    localparam int P_BFWD2  = 3;

    localparam logic [SEL_W-1:0] LOAD_LAT_IDX = SEL_W'(LOAD_LAT);
    localparam logic [SEL_W-1:0] BR_MIN_IDX   = SEL_W'(BR_FWD_MIN);
    localparam logic [1:0]       FLUSH_LOAD   = 2'(FLUSH_LEN);
    localparam logic [SEL_W-1:0] SEL_ONE      = SEL_W'(1);

    sb_entry_t         entryReg [DEPTH];
    sb_entry_t         entryNext0;

    logic [REG_AW-1:0] pickSrc  [NUM_PICK];
    logic              pickUsed [NUM_PICK];
    logic              pickHit  [NUM_PICK];
    logic [SEL_W-1:0]  pickIdx  [NUM_PICK];
    logic              pickLoad [NUM_PICK];

    logic [1:0]        flushCntReg;
    logic [1:0]        flushCntNext;
    logic [SEL_W-1:0]  fwd1Reg;
    logic [SEL_W-1:0]  fwd2Reg;
    logic [SEL_W-1:0]  fwd1Next;
    logic [SEL_W-1:0]  fwd2Next;

    logic              loadUseHaz;
    logic              branchHaz;
    logic              issue;
    logic              jumpTake;

    // Route decode sources to the pickers; branch pickers only see real branches.
    always_comb begin
        pickSrc[P_FWD1]   = id_rs1;
        pickSrc[P_FWD2]   = id_rs2;
        pickSrc[P_BFWD1]  = id_rs1;
        pickSrc[P_BFWD2]  = id_rs2;
        pickUsed[P_FWD1]  = id_rs1_used;
        pickUsed[P_FWD2]  = id_rs2_used;
        pickUsed[P_BFWD1] = id_rs1_used && id_branch && id_valid;
        pickUsed[P_BFWD2] = id_rs2_used && id_branch && id_valid;
    end

    generate
        for (genvar gi = 0; gi < NUM_PICK; gi++) begin : gPick
            hazard_fwd_pick #(
                .REG_AW (REG_AW),
                .DEPTH  (DEPTH)
            ) uPick (
                .entries (entryReg),
                .src     (pickSrc[gi]),
                .used    (pickUsed[gi]),
                .hit     (pickHit[gi]),
                .idx     (pickIdx[gi]),
                .isLoad  (pickLoad[gi])
            );
        end
    endgenerate

    // Hazard detection, issue/jump qualification and combinational selects.
    // A load whose youngest-match index is still below LOAD_LAT has not
    // produced data in time for the consumer's EX cycle; a branch operand
    // below BR_FWD_MIN cannot reach the decode comparator yet.
    always_comb begin
        loadUseHaz = (pickHit[P_FWD1] && pickLoad[P_FWD1] && (pickIdx[P_FWD1] < LOAD_LAT_IDX))
                  || (pickHit[P_FWD2] && pickLoad[P_FWD2] && (pickIdx[P_FWD2] < LOAD_LAT_IDX));
        branchHaz  = id_branch
                  && ((pickHit[P_BFWD1] && (pickIdx[P_BFWD1] < BR_MIN_IDX))
                   || (pickHit[P_BFWD2] && (pickIdx[P_BFWD2] < BR_MIN_IDX)));

        stall    = id_valid && (loadUseHaz || branchHaz);
        flush    = (flushCntReg != 2'd0);
        issue    = id_valid && !stall && !flush;
        jumpTake = id_jump && id_valid && !stall && !flush;

        bfwd1_sel = pickHit[P_BFWD1] ? (pickIdx[P_BFWD1] + SEL_ONE) : SEL_RF;
        bfwd2_sel = pickHit[P_BFWD2] ? (pickIdx[P_BFWD2] + SEL_ONE) : SEL_RF;
    end

    // Next scoreboard head, EX selects and flush counter.
    always_comb begin
        entryNext0 = '0;
        fwd1Next   = SEL_RF;
        fwd2Next   = SEL_RF;
        if (issue) begin
            entryNext0.valid = 1'b1;
            entryNext0.wr    = id_wr;
            entryNext0.load  = id_load;
            entryNext0.rd    = SB_RD_W'(id_rd);
            if (pickHit[P_FWD1]) begin
                fwd1Next = pickIdx[P_FWD1] + SEL_ONE;
            end
            if (pickHit[P_FWD2]) begin
                fwd2Next = pickIdx[P_FWD2] + SEL_ONE;
            end
        end

        flushCntNext = flushCntReg;
        if (jumpTake) begin
            flushCntNext = FLUSH_LOAD;
        end else if (flushCntReg != 2'd0) begin
            flushCntNext = flushCntReg - 2'd1;
        end
    end

    // Scoreboard shift, EX select registers and flush counter state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entryReg[i] <= '0;
            end
            fwd1Reg     <= SEL_RF;
            fwd2Reg     <= SEL_RF;
            flushCntReg <= 2'd0;
        end else begin
            entryReg[0] <= entryNext0;
            for (int i = 1; i < DEPTH; i++) begin
                entryReg[i] <= entryReg[i-1];
            end
            fwd1Reg     <= fwd1Next;
            fwd2Reg     <= fwd2Next;
            flushCntReg <= flushCntNext;
        end
    end

    assign fwd1_sel = fwd1Reg;
    assign fwd2_sel = fwd2Reg;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCntReg;
    logic [CNT_W-1:0] flushCntPerfReg;

    // Saturating cycle counters for stall and flush activity.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stallCntReg     <= '0;
            flushCntPerfReg <= '0;
        end else begin
            if (stall && (stallCntReg != {CNT_W{1'b1}})) begin
                stallCntReg <= stallCntReg + CNT_W'(1);
            end
            if (flush && (flushCntPerfReg != {CNT_W{1'b1}})) begin
                flushCntPerfReg <= flushCntPerfReg + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stallCntReg;
    assign flush_cnt = flushCntPerfReg;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed instruction stream, an
// issue-history model checked every cycle, plus hand-computed expectations.
// Honours HAZARD_PERF_CNT_EN for the performance counter ports.
module tb_hazard_scoreboard;

    localparam int DEPTH      = 3;
    localparam int LOAD_LAT   = 1;
    localparam int BR_FWD_MIN = 2;
    localparam int FLUSH_LEN  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [2:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_wr, id_load, id_branch, id_jump;
    logic [2:0] fwd1_sel, fwd2_sel, bfwd1_sel, bfwd2_sel;
    logic       stall, flush;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    hazard_scoreboard #(
        .REG_AW     (3),
        .DEPTH      (DEPTH),
        .LOAD_LAT   (LOAD_LAT),
        .BR_FWD_MIN (BR_FWD_MIN),
        .FLUSH_LEN  (FLUSH_LEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_wr       (id_wr),
        .id_load     (id_load),
        .id_branch   (id_branch),
        .id_jump     (id_jump),
        .fwd1_sel    (fwd1_sel),
        .fwd2_sel    (fwd2_sel),
        .bfwd1_sel   (bfwd1_sel),
        .bfwd2_sel   (bfwd2_sel),
        .stall       (stall),
        .flush       (flush)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // hist[k] is whatever was issued k+1 cycles ago (front = most recent).
    typedef struct { bit valid; bit wr; bit load; bit [2:0] rd; } rec_t;
    rec_t hist[$];
    int   flushLeft = 0;
    int   expFwd1 = 0, expFwd2 = 0;
    longint expStallCnt = 0, expFlushCnt = 0;
    bit   chkEn = 0;

    // How many cycles ago (minus one) the most recent writer of s issued; -1 if none.
    function automatic int age(input bit [2:0] s, input bit u);
        if (!u || s == 0) return -1;
        for (int k = 0; k < hist.size() && k < DEPTH; k++)
            if (hist[k].valid && hist[k].wr && hist[k].rd == s) return k;
        return -1;
    endfunction

    function automatic bit mStall();
        int a1, a2, b1, b2;
        bit ld;
        if (!id_valid) return 0;
        a1 = age(id_rs1, id_rs1_used);
        a2 = age(id_rs2, id_rs2_used);
        ld = (a1 >= 0 && hist[a1].load && a1 < LOAD_LAT) ||
             (a2 >= 0 && hist[a2].load && a2 < LOAD_LAT);
        b1 = age(id_rs1, id_rs1_used && id_branch);
        b2 = age(id_rs2, id_rs2_used && id_branch);
        return ld || (id_branch && ((b1 >= 0 && b1 < BR_FWD_MIN) || (b2 >= 0 && b2 < BR_FWD_MIN)));
    endfunction

    function automatic int mBsel(input bit [2:0] s, input bit u);
        int a;
        a = age(s, u && id_branch && id_valid);
        return (a < 0) ? 0 : a + 1;
    endfunction

    // Advance the model on each clock edge.
    always @(posedge clk) begin
        if (!reset) begin
            hist.delete();
            flushLeft = 0; expFwd1 = 0; expFwd2 = 0;
            expStallCnt = 0; expFlushCnt = 0;
            chkEn = 1;
        end else begin
            bit st, fl, iss;
            int a1, a2;
            rec_t r;
            st  = mStall();
            fl  = (flushLeft > 0);
            iss = id_valid && !st && !fl;
            a1  = age(id_rs1, id_rs1_used);
            a2  = age(id_rs2, id_rs2_used);
            expFwd1 = (iss && a1 >= 0) ? a1 + 1 : 0;
            expFwd2 = (iss && a2 >= 0) ? a2 + 1 : 0;
            if (st) expStallCnt++;
            if (fl) expFlushCnt++;
            if (id_jump && id_valid && !st && !fl) flushLeft = FLUSH_LEN;
            else if (flushLeft > 0) flushLeft--;
            r.valid = iss; r.wr = id_wr; r.load = id_load; r.rd = id_rd;
            hist.push_front(r);
            while (hist.size() > DEPTH) void'(hist.pop_back());
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chkEn) begin
            chk("m_stall", stall, mStall());
            chk("m_flush", flush, flushLeft > 0);
            chk("m_fwd1", fwd1_sel, expFwd1);
            chk("m_fwd2", fwd2_sel, expFwd2);
            chk("m_bfwd1", bfwd1_sel, mBsel(id_rs1, id_rs1_used));
            chk("m_bfwd2", bfwd2_sel, mBsel(id_rs2, id_rs2_used));
`ifdef HAZARD_PERF_CNT_EN
            chk("m_stall_cnt", stall_cnt, expStallCnt);
            chk("m_flush_cnt", flush_cnt, expFlushCnt);
`endif
        end
    end

    // ---------------- stimulus ----------------
    int cyc = 0;

    task automatic drive(input bit v, input logic [2:0] rs1, input bit u1,
                         input logic [2:0] rs2, input bit u2, input logic [2:0] rd,
                         input bit wr, input bit ld, input bit br, input bit jp);
        @(posedge clk);
        #1;
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_wr = wr; id_load = ld; id_branch = br; id_jump = jp;
        @(negedge clk);
        cyc++;
        $display("cyc %0d: v=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d wr=%0b ld=%0b br=%0b jp=%0b -> stall=%0b flush=%0b fwd=%0d,%0d bfwd=%0d,%0d",
                 cyc, v, rs1, u1, rs2, u2, rd, wr, ld, br, jp,
                 stall, flush, fwd1_sel, fwd2_sel, bfwd1_sel, bfwd2_sel);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_wr = 0; id_load = 0; id_branch = 0; id_jump = 0;
        idle(); idle();
        reset = 1'b1;

        idle();
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        chk("rst_fwd1", fwd1_sel, 0);
        chk("rst_bfwd1", bfwd1_sel, 0);

        // ALU chain: add r1 ; add r2,r1,r1
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        drive(1, 1, 1, 1, 1, 2, 1, 0, 0, 0);
        chk("alu_stall", stall, 0);
        idle();
        chk("alu_fwd1", fwd1_sel, 1);
        chk("alu_fwd2", fwd2_sel, 1);

        // Load-use: load r3 ; add r4,r3,r0
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
        drive(1, 3, 1, 0, 1, 4, 1, 0, 0, 0);
        chk("lu_stall1", stall, 1);
        drive(1, 3, 1, 0, 1, 4, 1, 0, 0, 0);
        chk("lu_stall2", stall, 0);
        chk("lu_bubble", fwd1_sel, 0);
        idle();
        chk("lu_fwd1", fwd1_sel, 2);
        chk("lu_fwd2", fwd2_sel, 0);

        // Branch: add r5 ; beq r5,r2
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        drive(1, 5, 1, 2, 1, 0, 0, 0, 1, 0);
        chk("br_stall1", stall, 1);
        drive(1, 5, 1, 2, 1, 0, 0, 0, 1, 0);
        chk("br_stall2", stall, 1);
        drive(1, 5, 1, 2, 1, 0, 0, 0, 1, 0);
        chk("br_stall3", stall, 0);
        chk("br_bfwd1", bfwd1_sel, 3);
        chk("br_bfwd2", bfwd2_sel, 0);
        idle();

        // Jump: flush exactly FLUSH_LEN cycles
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("j_flush0", flush, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("j_flush1", flush, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("j_flush2", flush, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("j_flush3", flush, 0);

        // Jump blocked by stall, re-presented, then a jump inside the flush window
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("js_stall", stall, 1);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("js_noflush", flush, 0);
        chk("js_nostall", stall, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("jf_flush1", flush, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("jf_flush2", flush, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("jf_flush3", flush, 0);

        // r0 destination never matches
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 1, 6, 1, 0, 0, 0);
        chk("r0_stall", stall, 0);
        idle();
        chk("r0_fwd1", fwd1_sel, 0);
        chk("r0_fwd2", fwd2_sel, 0);

        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("pc_stall", stall_cnt, 4);
        chk("pc_flush", flush_cnt, 4);
`endif

        // Reset with a populated scoreboard
        reset = 1'b0;
        drive(1, 7, 1, 7, 1, 1, 1, 0, 0, 0);
        reset = 1'b1;
        drive(1, 7, 1, 7, 1, 2, 1, 0, 1, 0);
        chk("mr_stall", stall, 0);
        chk("mr_bfwd1", bfwd1_sel, 0);
        chk("mr_fwd1", fwd1_sel, 0);
        idle();
        chk("mr_fwd1b", fwd1_sel, 0);
        chk("mr_fwd2b", fwd2_sel, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("mr_stall_cnt", stall_cnt, 0);
        chk("mr_flush_cnt", flush_cnt, 0);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
